// File: rtl/imem_arbiter_pkg.sv
// Shared arbiter types: FSM state encoding, default sizing and the word-range helper.
// Everything here is purely declarative and adds no logic or latency of its own.
package imem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LOAD    = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam int unsigned DEPTH_DEF      = 256;
    localparam int unsigned STARVE_MAX_DEF = 4;

    // Takes the word index (byte address already shifted right by two).
    function automatic logic word_in_range(input logic [29:0] word_idx, input int unsigned depth);
        return {2'b00, word_idx} < 32'(depth);
    endfunction

endpackage

// File: rtl/imem_arbiter.sv
// Single-port IMEM arbiter: the fetch stage owns the port in RUN, the loader wins after starvation or during LOAD.
// Zero-latency combinational grant and stall; the loader is backpressured through LD_ready_out, fetch through IF_stall_out.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = DEPTH_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                     clk_in,
    input  logic                     n_rst_in,
    input  logic                     IF_req_in,
    input  logic [31:0]              IF_addr_in,
    output logic                     IF_stall_out,
    output logic [31:0]              IF_ir_out,
    output logic                     IF_flush_out,
    input  logic                     LD_start_in,
    input  logic                     LD_valid_in,
    output logic                     LD_ready_out,
    input  logic [31:0]              LD_addr_in,
    input  logic [31:0]              LD_data_in,
    input  logic                     LD_done_in,
    output logic [$clog2(DEPTH)-1:0] mem_addr_out,
    output logic                     mem_we_out,
    output logic [31:0]              mem_wdata_out,
    input  logic [31:0]              mem_rdata_in,
    output logic [15:0]              ld_count_out,
    output logic                     err_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(STARVE_MAX) + 1;
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [15:0]   ld_count_q, ld_count_d;
    logic          err_q, err_d;

    logic ld_in_range;
    logic if_in_range;
    logic ld_owns;
    logic xfer;
    logic wr_ok;
    logic stall;
    logic flush;
    logic ld_ready;
    logic unused_addr_lsbs;

    assign ld_in_range      = word_in_range(LD_addr_in[31:2], DEPTH);
    assign if_in_range      = word_in_range(IF_addr_in[31:2], DEPTH);
    assign unused_addr_lsbs = ^{IF_addr_in[1:0], LD_addr_in[1:0]};

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        ld_count_d = ld_count_q;
        err_d      = err_q;
        ld_owns    = 1'b0;
        xfer       = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        ld_ready   = 1'b0;

        case (state_q)
            ST_RUN: begin
                // A LOAD request beats a same-cycle loader grant; no write happens then.
                ld_owns  = LD_valid_in && !LD_start_in && (!IF_req_in || starve_q == STARVE_LAST);
                xfer     = ld_owns;
                stall    = ld_owns;
                ld_ready = ld_owns;
                if (LD_start_in) begin
                    state_d    = ST_LOAD;
                    starve_d   = '0;
                    ld_count_d = '0;
                end else if (LD_valid_in && !ld_owns) begin
                    starve_d = starve_q + SW'(1);
                end else begin
                    starve_d = '0;
                end
            end
            ST_LOAD: begin
                ld_owns  = 1'b1;
                xfer     = LD_valid_in;
                stall    = 1'b1;
                ld_ready = 1'b1;
                if (LD_done_in) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                stall   = 1'b1;
                flush   = 1'b1;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        wr_ok = xfer && ld_in_range;
        if (wr_ok && ld_count_q != 16'hFFFF) begin
            ld_count_d = ld_count_q + 16'd1;
        end
        if (xfer && !ld_in_range) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!n_rst_in) begin
            state_q    <= ST_RUN;
            starve_q   <= '0;
            ld_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            ld_count_q <= ld_count_d;
            err_q      <= err_d;
        end
    end

    assign mem_we_out    = wr_ok && n_rst_in;
    assign mem_wdata_out = LD_data_in;
    assign mem_addr_out  = ld_owns ? LD_addr_in[AW+1:2] : IF_addr_in[AW+1:2];
    assign IF_stall_out  = stall;
    assign IF_flush_out  = flush;
    assign LD_ready_out  = ld_ready;
    // Out-of-range fetches read as NOP rather than aliasing into the array.
    assign IF_ir_out     = (!stall && if_in_range) ? mem_rdata_in : 32'd0;
    assign ld_count_out  = ld_count_q;
    assign err_out       = err_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized scoreboard bench for imem_arbiter against an ownership-rule reference model.
module tb_imem_arbiter;

    localparam int DEPTH      = 256;
    localparam int STARVE_MAX = 4;
    localparam int M_RUN = 0, M_LOAD = 1, M_REL = 2;

    logic        clk_in = 1'b0;
    logic        n_rst_in;
    logic        IF_req_in;
    logic [31:0] IF_addr_in;
    logic        IF_stall_out;
    logic [31:0] IF_ir_out;
    logic        IF_flush_out;
    logic        LD_start_in;
    logic        LD_valid_in;
    logic        LD_ready_out;
    logic [31:0] LD_addr_in;
    logic [31:0] LD_data_in;
    logic        LD_done_in;
    logic [7:0]  mem_addr_out;
    logic        mem_we_out;
    logic [31:0] mem_wdata_out;
    logic [31:0] mem_rdata_in;
    logic [15:0] ld_count_out;
    logic        err_out;

    imem_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_in(clk_in), .n_rst_in(n_rst_in),
        .IF_req_in(IF_req_in), .IF_addr_in(IF_addr_in), .IF_stall_out(IF_stall_out),
        .IF_ir_out(IF_ir_out), .IF_flush_out(IF_flush_out),
        .LD_start_in(LD_start_in), .LD_valid_in(LD_valid_in), .LD_ready_out(LD_ready_out),
        .LD_addr_in(LD_addr_in), .LD_data_in(LD_data_in), .LD_done_in(LD_done_in),
        .mem_addr_out(mem_addr_out), .mem_we_out(mem_we_out), .mem_wdata_out(mem_wdata_out),
        .mem_rdata_in(mem_rdata_in), .ld_count_out(ld_count_out), .err_out(err_out)
    );

    always #5 clk_in = ~clk_in;

    // Memory content stand-in: every word reads a distinct address-derived pattern.
    function automatic logic [31:0] mem_word(input logic [7:0] w);
        return {w, ~w, w ^ 8'h5A, 8'hC3};
    endfunction
    assign mem_rdata_in = mem_word(mem_addr_out);

    typedef struct {
        bit          chk;
        bit          chk_stall;
        bit          chk_addr;
        bit          stall;
        logic [31:0] ir;
        bit          flush;
        bit          ready;
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [15:0] cnt;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_mis = 0;

    int m_mode = M_RUN;
    int m_wait = 0;
    int m_cnt  = 0;
    bit m_err  = 1'b0;

    task automatic drive(input bit rst_n, input bit req, input logic [31:0] ifa,
                         input bit start, input bit vld, input logic [31:0] lda,
                         input logic [31:0] dat, input bit done);
        exp_t e;
        bit   ld_ok, if_ok, xfer, win;
        int   ldw, ifw;
        @(posedge clk_in);
        #1;
        n_rst_in = rst_n; IF_req_in = req; IF_addr_in = ifa; LD_start_in = start;
        LD_valid_in = vld; LD_addr_in = lda; LD_data_in = dat; LD_done_in = done;

        e = '{default: '0};
        ld_ok = (lda >> 2) < DEPTH;
        if_ok = (ifa >> 2) < DEPTH;
        ldw   = int'((lda >> 2) % DEPTH);
        ifw   = int'((ifa >> 2) % DEPTH);
        xfer  = 1'b0;
        if (!rst_n) begin
            e.chk = 1'b0;
            e.we  = 1'b0;
            m_mode = M_RUN; m_wait = 0; m_cnt = 0; m_err = 1'b0;
        end else begin
            e.chk   = 1'b1;
            e.cnt   = 16'(m_cnt);
            e.err   = m_err;
            e.wdata = dat;
            e.chk_stall = 1'b1;
            e.chk_addr  = 1'b1;
            case (m_mode)
                M_RUN: begin
                    win = vld && !start && (!req || m_wait == STARVE_MAX - 1);
                    xfer = win;
                    e.ready = win;
                    e.stall = win;
                    e.chk_stall = req || !win;
                    e.addr = 8'(win ? ldw : ifw);
                    if (start) begin
                        m_mode = M_LOAD; m_cnt = 0; m_wait = 0;
                    end else if (vld && !win) begin
                        m_wait++;
                    end else begin
                        m_wait = 0;
                    end
                end
                M_LOAD: begin
                    xfer = vld;
                    e.ready = 1'b1;
                    e.stall = 1'b1;
                    e.chk_addr = vld;
                    e.addr = 8'(ldw);
                    if (done) m_mode = M_REL;
                end
                default: begin
                    e.stall = 1'b1;
                    e.flush = 1'b1;
                    e.chk_addr = 1'b0;
                    m_mode = M_RUN;
                end
            endcase
            e.we = xfer && ld_ok;
            e.ir = (e.stall || !if_ok) ? 32'd0 : mem_word(8'(ifw));
            if (xfer) begin
                if (ld_ok) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
                else m_err = 1'b1;
            end
        end
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h (vector %0d, t=%0t)", nm, act, req, n_vec, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            cmp("mem_we", 32'(mem_we_out), 32'(e.we));
            if (e.chk) begin
                if (e.chk_stall) begin
                    cmp("if_stall", 32'(IF_stall_out), 32'(e.stall));
                    cmp("if_ir", IF_ir_out, e.ir);
                end
                cmp("if_flush", 32'(IF_flush_out), 32'(e.flush));
                cmp("ld_ready", 32'(LD_ready_out), 32'(e.ready));
                cmp("ld_count", 32'(ld_count_out), 32'(e.cnt));
                cmp("err", 32'(err_out), 32'(e.err));
                if (e.chk_addr) cmp("mem_addr", 32'(mem_addr_out), 32'(e.addr));
                if (e.we) cmp("mem_wdata", mem_wdata_out, e.wdata);
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = $urandom;
        else a = 32'($urandom_range(0, 32'h3FF));
        return a;
    endfunction

    initial begin
        n_rst_in = 1'b0; IF_req_in = 1'b0; IF_addr_in = '0; LD_start_in = 1'b0;
        LD_valid_in = 1'b0; LD_addr_in = '0; LD_data_in = '0; LD_done_in = 1'b0;

        drive(0, 1, 32'h4, 1, 1, 32'h8, 32'h11, 0);
        drive(0, 0, 32'h0, 0, 1, 32'h8, 32'h12, 1);
        drive(1, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 4; i++) drive(1, 1, 32'h20 + 4 * i, 0, 1, 32'h10, 32'hD0 + i, 0);
        drive(1, 1, 32'h30, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 1, 32'h34, 1, 0, 32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) drive(1, 1, 32'h0, 0, 1, 32'(4 * i), 32'hA0 + i, 0);
        drive(1, 1, 32'h0, 0, 1, 32'hC, 32'hA3, 1);
        drive(1, 1, 32'h0, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 1, 32'h4, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 32'h0, 0, 1, 32'h400, 32'hEE, 0);
        drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 1);
        drive(1, 1, 32'h3FC, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 1, 32'h400, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 32'h0, 0, 1, 32'h40, 32'h55, 0);
        drive(0, 1, 32'h8, 0, 1, 32'h44, 32'h66, 0);
        drive(1, 1, 32'h8, 0, 0, 32'h0, 32'h0, 0);

        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 99) != 0,
                  $urandom_range(0, 9) < 7, rnd_addr(),
                  $urandom_range(0, 99) < 4,
                  $urandom_range(0, 9) < 6, rnd_addr(), $urandom,
                  $urandom_range(0, 99) < 15);
        end
        drive(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0);

        repeat (3) @(posedge clk_in);
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
